// File: rtl/decoder_3of6_stream.sv
// Streaming 3-of-6 symbol receiver: packs NUM_SYMBOLS checked symbols into one payload word.
// Define DEC3OF6_DROP_ERR_EN to discard completed frames that contain any errored symbol.
module decoder_3of6_stream #(
    parameter int NUM_SYMBOLS = 8,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 sym_in,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    output logic [3*NUM_SYMBOLS-1:0]   payload,
    output logic                       pld_valid,
    input  logic                       pld_ready,
    output logic [NUM_SYMBOLS-1:0]     err_sym_mask,
    output logic                       error_3of6,
    output logic [ERR_CNT_W-1:0]       err_count,
    input  logic                       clr_err
);

    localparam int K_W   = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
    localparam int PLD_W = 3 * NUM_SYMBOLS;
    localparam logic [K_W-1:0]       K_LAST  = K_W'(NUM_SYMBOLS - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

`ifdef DEC3OF6_DROP_ERR_EN
    localparam logic DROP_ERR = 1'b1;
`else
    localparam logic DROP_ERR = 1'b0;
`endif

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                  state_r, state_next_s;
    logic [K_W-1:0]          k_r, k_next_s, idx_s;
    logic [PLD_W-1:0]        payload_r, payload_next_s;
    logic [NUM_SYMBOLS-1:0]  mask_r, mask_base_s, mask_next_s;
    logic                    pld_valid_r;
    logic                    error_r;
    logic [ERR_CNT_W-1:0]    err_count_r;
    logic                    sym_ready_s;
    logic                    accept_s;
    logic                    handshake_s;
    logic                    last_s;
    logic                    frame_err_s;
    logic                    drop_s;
    logic                    sym_legal_s;

    // A symbol is legal when exactly three of its six bits are set.
    function automatic logic is_3of6(input logic [5:0] s);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            cnt = cnt + {2'b00, s[i]};
        end
        return (cnt == 3'd3);
    endfunction

    // Ready is held low in reset and follows downstream ready while a frame is held.
    always_comb begin
        sym_ready_s = 1'b0;
        if (rst) begin
            sym_ready_s = 1'b0;
        end else if (state_r == COLLECT) begin
            sym_ready_s = 1'b1;
        end else begin
            sym_ready_s = pld_ready;
        end
    end

    // Datapath: place the accepted symbol at its slot; in FULL a new symbol is slot 0.
    always_comb begin
        accept_s       = sym_valid & sym_ready_s;
        handshake_s    = pld_valid_r & pld_ready;
        sym_legal_s    = is_3of6(sym_in);
        idx_s          = (state_r == FULL) ? K_W'(0) : k_r;
        last_s         = accept_s & (idx_s == K_LAST);
        mask_base_s    = handshake_s ? {NUM_SYMBOLS{1'b0}} : mask_r;
        mask_next_s    = mask_base_s;
        payload_next_s = payload_r;
        for (int k = 0; k < NUM_SYMBOLS; k++) begin
            mask_next_s[k] = (accept_s && (idx_s == K_W'(k))) ? ~sym_legal_s : mask_base_s[k];
            payload_next_s[3*k +: 3] = (accept_s && (idx_s == K_W'(k))) ? sym_in[5:3]
                                                                      : payload_r[3*k +: 3];
        end
        frame_err_s = last_s & (|mask_next_s);
        drop_s      = DROP_ERR & frame_err_s;
    end

    // Next-state and slot index selection.
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        if (last_s) begin
            state_next_s = drop_s ? COLLECT : FULL;
            k_next_s     = K_W'(0);
        end else if (accept_s) begin
            state_next_s = COLLECT;
            k_next_s     = idx_s + K_W'(1);
        end else if (handshake_s) begin
            state_next_s = COLLECT;
            k_next_s     = K_W'(0);
        end else begin
            state_next_s = state_r;
            k_next_s     = k_r;
        end
    end

    // Frame assembly FSM with registered payload, mask and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= COLLECT;
            k_r         <= K_W'(0);
            payload_r   <= {PLD_W{1'b0}};
            mask_r      <= {NUM_SYMBOLS{1'b0}};
            pld_valid_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            k_r         <= k_next_s;
            payload_r   <= payload_next_s;
            mask_r      <= drop_s ? {NUM_SYMBOLS{1'b0}} : mask_next_s;
            error_r     <= drop_s ? 1'b0 : (|mask_next_s);
            pld_valid_r <= (state_next_s == FULL);
        end
    end

    // Saturating errored-frame counter; clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (clr_err) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (frame_err_s && (err_count_r != CNT_MAX)) begin
            err_count_r <= err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign sym_ready    = sym_ready_s;
    assign payload      = payload_r;
    assign pld_valid    = pld_valid_r;
    assign err_sym_mask = mask_r;
    assign error_3of6   = error_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_decoder_3of6_stream.sv
// Directed bench for decoder_3of6_stream: default build, narrow counter and single-symbol variants.
module tb_decoder_3of6_stream;

    logic        clk;
    logic        rst;
    logic [5:0]  sym_in;
    logic        sym_valid;
    logic        pld_ready;
    logic        clr_err;

    logic        sym_ready;
    logic [23:0] payload;
    logic        pld_valid;
    logic [7:0]  err_sym_mask;
    logic        error_3of6;
    logic [7:0]  err_count;

    logic        w2_sym_ready;
    logic [23:0] w2_payload;
    logic        w2_pld_valid;
    logic [7:0]  w2_mask;
    logic        w2_error;
    logic [1:0]  w2_err_count;

    logic        n1_sym_ready;
    logic [2:0]  n1_payload;
    logic        n1_pld_valid;
    logic [0:0]  n1_mask;
    logic        n1_error;
    logic [7:0]  n1_err_count;

    int n_compared;
    int n_mismatched;

    decoder_3of6_stream #(.NUM_SYMBOLS(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .payload(payload), .pld_valid(pld_valid), .pld_ready(pld_ready),
        .err_sym_mask(err_sym_mask), .error_3of6(error_3of6), .err_count(err_count),
        .clr_err(clr_err)
    );

    decoder_3of6_stream #(.NUM_SYMBOLS(8), .ERR_CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(w2_sym_ready),
        .payload(w2_payload), .pld_valid(w2_pld_valid), .pld_ready(pld_ready),
        .err_sym_mask(w2_mask), .error_3of6(w2_error), .err_count(w2_err_count),
        .clr_err(clr_err)
    );

    decoder_3of6_stream #(.NUM_SYMBOLS(1), .ERR_CNT_W(8)) dut_n1 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(n1_sym_ready),
        .payload(n1_payload), .pld_valid(n1_pld_valid), .pld_ready(pld_ready),
        .err_sym_mask(n1_mask), .error_3of6(n1_error), .err_count(n1_err_count),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Present one symbol at a falling edge; it is taken on the next rising edge.
    task automatic drive_beat(input logic [5:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_compared++;
        if (pld_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_pld_valid got=%b exp=0", pld_valid); end
        n_compared++;
        if (payload !== 24'h000000) begin n_mismatched++; $display("FAIL reset_payload got=%h exp=000000", payload); end
        n_compared++;
        if (err_count !== 8'd0) begin n_mismatched++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        n_compared++;
        if (sym_ready !== 1'b0) begin n_mismatched++; $display("FAIL reset_sym_ready got=%b exp=0", sym_ready); end
        rst = 1'b0;
        #1;
        n_compared++;
        if (sym_ready !== 1'b1) begin n_mismatched++; $display("FAIL post_reset_sym_ready got=%b exp=1", sym_ready); end
        @(negedge clk);
    endtask

    task automatic test_clean_frame();
        pld_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive_beat(6'b000111);
        n_compared++;
        if (pld_valid !== 1'b0) begin n_mismatched++; $display("FAIL clean_early_valid got=%b exp=0", pld_valid); end
        drive_beat(6'b000111);
        sym_valid = 1'b0;
        n_compared++;
        if (pld_valid !== 1'b1) begin n_mismatched++; $display("FAIL clean_valid got=%b exp=1", pld_valid); end
        n_compared++;
        if (payload !== 24'h000000) begin n_mismatched++; $display("FAIL clean_payload got=%h exp=000000", payload); end
        n_compared++;
        if (err_sym_mask !== 8'h00) begin n_mismatched++; $display("FAIL clean_mask got=%h exp=00", err_sym_mask); end
        n_compared++;
        if (err_count !== 8'd0) begin n_mismatched++; $display("FAIL clean_err_count got=%0d exp=0", err_count); end
        @(negedge clk);
        n_compared++;
        if (pld_valid !== 1'b0) begin n_mismatched++; $display("FAIL clean_drain got=%b exp=0", pld_valid); end
    endtask

    task automatic test_ones_and_error();
        pld_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive_beat(6'b111000);
        sym_valid = 1'b0;
        n_compared++;
        if (payload !== 24'hFFFFFF) begin n_mismatched++; $display("FAIL ones_payload got=%h exp=FFFFFF", payload); end
        n_compared++;
        if (error_3of6 !== 1'b0) begin n_mismatched++; $display("FAIL ones_error got=%b exp=0", error_3of6); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) drive_beat((i == 3) ? 6'b111100 : 6'b111000);
        sym_valid = 1'b0;
`ifdef DEC3OF6_DROP_ERR_EN
        n_compared++;
        if (pld_valid !== 1'b0) begin n_mismatched++; $display("FAIL drop_valid got=%b exp=0", pld_valid); end
`else
        n_compared++;
        if (pld_valid !== 1'b1) begin n_mismatched++; $display("FAIL err_valid got=%b exp=1", pld_valid); end
        n_compared++;
        if (err_sym_mask !== 8'h08) begin n_mismatched++; $display("FAIL err_mask got=%h exp=08", err_sym_mask); end
        n_compared++;
        if (error_3of6 !== 1'b1) begin n_mismatched++; $display("FAIL err_flag got=%b exp=1", error_3of6); end
`endif
        n_compared++;
        if (err_count !== 8'd1) begin n_mismatched++; $display("FAIL err_count_one got=%0d exp=1", err_count); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [5:0] bp [8];
        bp = '{6'b000111, 6'b001011, 6'b010011, 6'b011001,
               6'b100011, 6'b101001, 6'b110001, 6'b111000};
        pld_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_beat(bp[i]);
        sym_in    = 6'b101010;
        sym_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_compared++;
            if (pld_valid !== 1'b1 || sym_ready !== 1'b0 || payload !== 24'hFAC688) begin
                n_mismatched++;
                $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b payload=%h exp 1 0 FAC688",
                         c, pld_valid, sym_ready, payload);
            end
            @(negedge clk);
        end
        pld_ready = 1'b1;
        #1;
        n_compared++;
        if (sym_ready !== 1'b1) begin n_mismatched++; $display("FAIL bp_passthru got=%b exp=1", sym_ready); end
        @(negedge clk);
        n_compared++;
        if (pld_valid !== 1'b0) begin n_mismatched++; $display("FAIL bp_release got=%b exp=0", pld_valid); end
        for (int i = 0; i < 7; i++) drive_beat(6'b000111);
        sym_valid = 1'b0;
        n_compared++;
        if (pld_valid !== 1'b1 || payload !== 24'h000005) begin
            n_mismatched++;
            $display("FAIL bp_next_frame got valid=%b payload=%h exp 1 000005", pld_valid, payload);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        pld_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_beat(6'b111000);
        sym_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_compared++;
        if (pld_valid !== 1'b0 || payload !== 24'h000000 || err_sym_mask !== 8'h00 ||
            error_3of6 !== 1'b0 || err_count !== 8'd0 || sym_ready !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midreset_outputs got valid=%b payload=%h mask=%h err=%b cnt=%0d ready=%b exp all 0",
                     pld_valid, payload, err_sym_mask, error_3of6, err_count, sym_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 7; i++) drive_beat(6'b000111);
        n_compared++;
        if (pld_valid !== 1'b0) begin n_mismatched++; $display("FAIL midreset_early got=%b exp=0", pld_valid); end
        drive_beat(6'b000111);
        sym_valid = 1'b0;
        n_compared++;
        if (pld_valid !== 1'b1 || payload !== 24'h000000) begin
            n_mismatched++;
            $display("FAIL midreset_frame got valid=%b payload=%h exp 1 000000", pld_valid, payload);
        end
        @(negedge clk);
    endtask

    task automatic test_err_saturation();
        logic [1:0] exp_cnt;
        pld_ready = 1'b1;
        clr_err   = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) drive_beat(6'b111111);
            exp_cnt = (f >= 2) ? 2'd3 : 2'(f + 1);
            n_compared++;
            if (w2_err_count !== exp_cnt) begin
                n_mismatched++;
                $display("FAIL sat_count frame=%0d got=%0d exp=%0d", f, w2_err_count, exp_cnt);
            end
        end
        for (int i = 0; i < 7; i++) drive_beat(6'b111111);
        clr_err = 1'b1;
        drive_beat(6'b111111);
        clr_err = 1'b0;
        n_compared++;
        if (w2_err_count !== 2'd0) begin n_mismatched++; $display("FAIL clr_priority got=%0d exp=0", w2_err_count); end
        for (int i = 0; i < 8; i++) drive_beat(6'b111111);
        sym_valid = 1'b0;
        n_compared++;
        if (w2_err_count !== 2'd1) begin n_mismatched++; $display("FAIL after_clr got=%0d exp=1", w2_err_count); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_single_symbol();
        logic [5:0] syms [4];
        logic [2:0] exp_bits [4];
        syms     = '{6'b101010, 6'b000111, 6'b111000, 6'b010101};
        exp_bits = '{3'b101, 3'b000, 3'b111, 3'b010};
        pld_ready = 1'b1;
        sym_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_beat(syms[i]);
            n_compared++;
            if (n1_pld_valid !== 1'b1 || n1_payload !== exp_bits[i] || n1_sym_ready !== 1'b1) begin
                n_mismatched++;
                $display("FAIL n1_beat%0d got valid=%b payload=%b ready=%b exp 1 %b 1",
                         i, n1_pld_valid, n1_payload, n1_sym_ready, exp_bits[i]);
            end
        end
        sym_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        sym_in       = 6'b000000;
        sym_valid    = 1'b0;
        pld_ready    = 1'b0;
        clr_err      = 1'b0;
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_clean_frame();
        test_ones_and_error();
        test_backpressure();
        test_reset_midframe();
        test_err_saturation();
        test_single_symbol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
